fft_frame_sink: RTL
===================

FFT_FRAME_SINK -- requirements
Module: fft_frame_sink

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, bit width of each stream beat and read word.
REQ-002 SHALL have parameter SAMPLE_COUNT, default 1024, beats per frame (power of two, >=4); ADDR_WIDTH = clog2(SAMPLE_COUNT).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_data  input  DATA_WIDTH  inbound stream beat.
REQ-006 SHALL have port s_valid  input  1  beat offered.
REQ-007 SHALL have port s_ready  output  1  beat accepted when s_valid && s_ready.
REQ-008 SHALL have port s_last  input  1  marks final beat of a frame.
REQ-009 SHALL have port frame_ready  output  1  a complete frame awaits claiming.
REQ-010 SHALL have port rd_start  input  1  one-cycle claim of oldest complete frame.
REQ-011 SHALL have port rd_en  input  1  random-read request.
REQ-012 SHALL have port rd_addr  input  ADDR_WIDTH  beat index within claimed frame.
REQ-013 SHALL have port rd_data  output  DATA_WIDTH  read result.
REQ-014 SHALL have port rd_valid  output  1  rd_data valid this cycle.
REQ-015 SHALL have port rd_done  input  1  one-cycle release of claimed frame.
REQ-016 SHALL have port frame_error  output  1  sticky misaligned-frame flag.
REQ-017 SHALL have port err_clear  input  1  clears frame_error and drop_count.
REQ-018 SHALL have port drop_count  output  8  saturating count of discarded frames.

Function
REQ-019 SHALL hold two banks of SAMPLE_COUNT words; each bank state FREE, FILLING, FULL, READING; 1-bit age pointer identifies older FULL bank.
REQ-020 Writer FSM SHALL have states FILL, DROP, WAIT; s_ready = 1 in FILL and DROP, 0 in WAIT.
REQ-021 FILL: accepted beat written at write_ptr of FILLING bank; write_ptr increments per accepted beat.
REQ-022 FILL, accepted beat at write_ptr = SAMPLE_COUNT-1 with s_last = 1: bank -> FULL, write_ptr -> 0; next FSM state FILL on other bank if FREE (that bank -> FILLING), else WAIT.
REQ-023 FILL, s_last = 1 at write_ptr < SAMPLE_COUNT-1 (short frame): frame discarded, write_ptr -> 0, same bank stays FILLING, frame_error set, drop_count +1.
REQ-024 FILL, write_ptr = SAMPLE_COUNT-1 with s_last = 0 (long frame): frame discarded, frame_error set, drop_count +1, state -> DROP.
REQ-025 DROP: beats accepted and discarded; accepted beat with s_last = 1 -> FILL, write_ptr = 0.
REQ-026 WAIT: on cycle after any bank becomes FREE, that bank -> FILLING, state -> FILL.
REQ-027 frame_ready SHALL be 1 iff a bank is FULL and no bank is READING, registered.
REQ-028 rd_start sampled with frame_ready = 1: older FULL bank -> READING, frame_ready 0 next cycle; rd_start otherwise ignored.
REQ-029 rd_en while a bank is READING: rd_data = word[rd_addr] of that bank, rd_valid = 1 exactly one cycle later; rd_en with no READING bank gives rd_valid = 0.
REQ-030 rd_done while READING: bank -> FREE next cycle; otherwise ignored; rd_done and rd_en same cycle: read completes.
REQ-031 drop_count SHALL saturate at 255; err_clear same cycle as new error: error wins (flag 1, count 1).
REQ-032 Frames SHALL be delivered in arrival order; no beat is ever overwritten in a FULL or READING bank.

Reset
REQ-033 rst SHALL force: all banks FREE except bank 0 FILLING, writer FILL, write_ptr 0, s_ready 1, frame_ready 0, rd_valid 0, rd_data 0, frame_error 0, drop_count 0; memory contents not cleared.
REQ-034 rst mid-frame or mid-read SHALL discard all frames without raising frame_error.

Structure
REQ-035 Bank-state encoding and writer-state encoding SHALL live in the shared project package with other stream constants.
REQ-036 One sub-module, frame_bank_ram (single write port, single registered read port, SAMPLE_COUNT x DATA_WIDTH), instantiated twice.

Verification
REQ-037 SAMPLE_COUNT=16: stream ramp 0..15, s_last on beat 15 -> frame_ready 1; rd_start, read addr 5 -> rd_data 5 one cycle later.
REQ-038 Three back-to-back frames (values 0x100+i, 0x200+i, 0x300+i), no rd_start -> s_ready 0 after frame 2; rd_start/read/rd_done frame 1 -> reads 0x10n, s_ready 1, frame 3 completes; next claim returns 0x20n.
REQ-039 s_last on beat 7 -> frame_error 1, drop_count 1; following clean 16-beat frame -> frame_ready 1, data intact.
REQ-040 18-beat frame, s_last on beat 17 -> drop_count 1, beats 16-17 dropped, no frame_ready; next clean frame captured.
REQ-041 Random s_valid/rd_en gaps with rst asserted mid-frame and mid-read -> all outputs at REQ-033 values next cycle, frame_error 0.
REQ-042 260 short frames -> drop_count 255; err_clear -> 0.

Source files
------------

// File: rtl/fft_frame_sink_pkg.sv
// fft_frame_sink_pkg: shared bank/writer encodings and stream constants
package fft_frame_sink_pkg;
  localparam int NUM_BANKS = 2;
  localparam int DROP_COUNT_WIDTH = 8;
  localparam logic [DROP_COUNT_WIDTH-1:0] DROP_MAX = '1;
  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } bank_state_t;
  typedef enum logic [1:0] {
    WR_FILL,
    WR_DROP,
    WR_WAIT
  } wr_state_t;
endpackage

// File: rtl/fft_frame_sink_ram.sv
// frame_bank_ram: one frame of storage, single write port, registered read port
module frame_bank_ram #(
  parameter int DATA_WIDTH = 12,
  parameter int SAMPLE_COUNT = 1024,
  localparam int ADDR_WIDTH = $clog2(SAMPLE_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [SAMPLE_COUNT];
  // storage is never cleared so it maps onto plain block RAM
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read register is cleared so rd_data comes out of reset at zero
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fft_frame_sink.sv
// fft_frame_sink: double-buffered frame capture with random-access readout
module fft_frame_sink
  import fft_frame_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int SAMPLE_COUNT = 1024,
  localparam int ADDR_WIDTH = $clog2(SAMPLE_COUNT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        s_last,
  output logic                        frame_ready,
  input  logic                        rd_start,
  input  logic                        rd_en,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid,
  input  logic                        rd_done,
  output logic                        frame_error,
  input  logic                        err_clear,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);
  bank_state_t bank_st [NUM_BANKS];
  bank_state_t bank_nxt [NUM_BANKS];
  wr_state_t wr_state, wr_nxt;
  logic wr_bank, wbank_nxt, old, old_nxt, rd_bank, rd_sel, free_sel;
  logic acc, at_end, rd_active, claim, err_set, fr_nxt;
  logic [ADDR_WIDTH-1:0] write_ptr, ptr_nxt;
  logic [NUM_BANKS-1:0] we, re;
  logic [DATA_WIDTH-1:0] q [NUM_BANKS];

  assign s_ready = wr_state != WR_WAIT;
  assign acc = s_valid && s_ready;
  assign at_end = write_ptr == ADDR_WIDTH'(SAMPLE_COUNT - 1);
  assign rd_active = bank_st[rd_bank] == BANK_READING;
  assign claim = rd_start && frame_ready;
  assign free_sel = bank_st[0] != BANK_FREE;
  assign rd_data = q[rd_sel];

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    assign we[i] = wr_state == WR_FILL && acc && wr_bank == 1'(i);
    assign re[i] = rd_en && rd_active && rd_bank == 1'(i);
    frame_bank_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .SAMPLE_COUNT(SAMPLE_COUNT)
    ) u_ram (
      .clk(clk),
      .rst(rst),
      .we(we[i]),
      .waddr(write_ptr),
      .wdata(s_data),
      .re(re[i]),
      .raddr(rd_addr),
      .rdata(q[i])
    );
  end

  // writer FSM, bank lifecycle and age tracking; the writer only ever touches
  // FILLING/FREE banks and the reader only FULL/READING, so updates never collide
  always_comb begin
    bank_nxt = bank_st;
    wr_nxt = wr_state;
    wbank_nxt = wr_bank;
    ptr_nxt = write_ptr;
    err_set = 1'b0;
    if (wr_state == WR_FILL && acc) begin
      if (!at_end) begin
        ptr_nxt = s_last ? '0 : write_ptr + ADDR_WIDTH'(1);
        err_set = s_last;
      end else if (s_last) begin
        ptr_nxt = '0;
        bank_nxt[wr_bank] = BANK_FULL;
        if (bank_st[!wr_bank] == BANK_FREE) begin
          bank_nxt[!wr_bank] = BANK_FILLING;
          wbank_nxt = !wr_bank;
        end else wr_nxt = WR_WAIT;
      end else begin
        ptr_nxt = '0;
        err_set = 1'b1;
        wr_nxt = WR_DROP;
      end
    end
    if (wr_state == WR_DROP && acc && s_last) wr_nxt = WR_FILL;
    if (wr_state == WR_WAIT && (bank_st[0] == BANK_FREE || bank_st[1] == BANK_FREE)) begin
      wbank_nxt = free_sel;
      bank_nxt[free_sel] = BANK_FILLING;
      wr_nxt = WR_FILL;
    end
    if (claim) bank_nxt[old] = BANK_READING;
    if (rd_done && rd_active) bank_nxt[rd_bank] = BANK_FREE;
    old_nxt = bank_nxt[old] == BANK_FULL ? old : !old;
    fr_nxt = (bank_nxt[0] == BANK_FULL || bank_nxt[1] == BANK_FULL) &&
             bank_nxt[0] != BANK_READING && bank_nxt[1] != BANK_READING;
  end

  // state registers plus the registered read-side handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= BANK_FILLING;
      bank_st[1] <= BANK_FREE;
      wr_state <= WR_FILL;
      wr_bank <= 1'b0;
      write_ptr <= '0;
      old <= 1'b0;
      rd_bank <= 1'b0;
      rd_sel <= 1'b0;
      rd_valid <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      bank_st <= bank_nxt;
      wr_state <= wr_nxt;
      wr_bank <= wbank_nxt;
      write_ptr <= ptr_nxt;
      old <= old_nxt;
      frame_ready <= fr_nxt;
      rd_valid <= rd_en && rd_active;
      if (claim) rd_bank <= old;
      if (rd_en && rd_active) rd_sel <= rd_bank;
    end
  end

  // sticky error and saturating drop counter; a new error beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_error <= 1'b0;
      drop_count <= '0;
    end else if (err_set) begin
      frame_error <= 1'b1;
      drop_count <= err_clear ? DROP_COUNT_WIDTH'(1) :
                    drop_count == DROP_MAX ? DROP_MAX : drop_count + DROP_COUNT_WIDTH'(1);
    end else if (err_clear) begin
      frame_error <= 1'b0;
      drop_count <= '0;
    end
  end
endmodule
